aes_key_expand: RTL and testbench
=================================

Name: aes_key_expand

Overview:
Iterative AES key-schedule engine. It is the sequential, parametrised successor to the single-round combinational key generator. It accepts a 128/192/256-bit cipher key (runtime-selectable), generates the full FIPS-197 word schedule at one 32-bit word per cycle, and stores every round key for random-access read. It sits between the key-load CSR path and the vector AES round datapath, which indexes round keys by round number.

Parameters:
MAX_NK, 8, largest supported key length in 32-bit words. Legal values are 4, 6 and 8. It sizes storage at 4*(MAX_NK+7) words.
RK_IDX_W, 4, width of the round-key index port.

Ports:
clock  input  1  single clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request expansion; sampled only in IDLE
key_len  input  2  0 = AES-128 (Nk=4, Nr=10), 1 = AES-192 (Nk=6, Nr=12), 2 = AES-256 (Nk=8, Nr=14), 3 = illegal
key  input  256  cipher key, MSB-aligned: w[0] = key[255:224]; for AES-128 only key[255:128] is used
ready  output  1  high in IDLE
busy  output  1  high in EXPAND
done  output  1  one-cycle pulse when the schedule completes
err  output  1  one-cycle pulse when start is sampled with an illegal key_len
rk_valid  output  1  stored schedule is complete and consistent
rk_idx  input  RK_IDX_W  round-key index, 0..Nr
rk_data  output  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]}; combinational from rk_idx

Behaviour:
- Reset values: ready=1, busy=0, done=0, err=0, rk_valid=0, rk_data=0. FSM resets to IDLE. Word storage need not be cleared.
- FSM states:
  - IDLE: on start with a legal key_len, load w[0..Nk-1] from key, latch Nk/Nr, set i=Nk, rcon=8'h01, go to EXPAND, clear rk_valid.
  - IDLE, illegal start: key_len=3, or Nk>MAX_NK, pulses err for one cycle and stays in IDLE with rk_valid unchanged.
  - EXPAND: each cycle write one word w[i], i++. When writing the last word i=4*(Nr+1)-1, go to DONE.
  - DONE: one cycle; done=1, rk_valid=1, then IDLE.
- Word rule, with temp = w[i-1]:
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon = xtime(rcon).
  - Else if Nk==8 and i mod Nk == 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
  - RotWord is applied BEFORE SubWord.
  - i mod Nk is tracked by a wrapping phase counter; no divider.
- rcon sequence: 01,02,04,08,10,20,40,80,1B,36. xtime: shift left 1, XOR 8'h1B if the MSB was set.
- Latency: start sampled at edge 0. Words are written at edges 1..G, where G = 40, 46 or 52 for Nk = 4, 6, 8. done and rk_valid are visible after edge G+1.
- start during EXPAND or DONE is ignored; no queueing.
- A start in IDLE while rk_valid=1 begins a new expansion, and rk_valid drops on the same edge.
- rk_data reads 0 when rk_valid=0 or rk_idx>Nr.
- reset mid-EXPAND: return to IDLE next edge, rk_valid=0, no done pulse.
- key and key_len are captured at start; later changes have no effect.

Decomposition:
- Shared package aes_pkg holds:
  - key_len encodings and the Nk/Nr lookup
  - MAX_WORDS = 4*(MAX_NK+7)
  - the xtime function and the rcon initial value
- One sub-module: the existing 4-byte S-box block aes_4sbox, instantiated once and shared by both SubWord cases.
- The FSM, counters and word array stay in aes_key_expand.

Test Plan:
1. AES-128 key 2b7e151628aed2a6abf7158809cf4f3c:
   - done after edge 41.
   - rk_idx=1 gives a0fafe1788542cb123a339392a6c7605.
   - rk_idx=8 gives ead27321b58dbad2312bf5607f8d292f.
   - rk_idx=9 gives ac7766f319fadc2128d12941575c006e (exercises rcon 80 and 1B).
   - rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
2. AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
   - done after edge 47.
   - rk_idx=12 gives e98ba06f448c773c8ecc720401002202.
   - rk_idx=13 gives 0.
3. AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
   - done after edge 53.
   - rk_idx=14 gives fe4890d1e6188d0b046df344706c631e (exercises the i mod 8 == 4 SubWord path).
4. start with key_len=3: err pulses one cycle, ready stays 1, rk_valid and rk_data unchanged from the prior schedule.
5. reset asserted 20 cycles into an AES-256 expansion:
   - next cycle: ready=1, rk_valid=0, no done pulse.
   - A fresh AES-128 start then completes correctly (case 1 values).
6. Second start pulse during EXPAND is ignored: one done pulse only, correct keys. A back-to-back start in IDLE after done drops rk_valid on the start edge.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-schedule encodings, Nk/Nr lookup and rcon arithmetic
package aes_pkg;
    typedef enum logic [1:0] {KL_128 = 2'd0, KL_192 = 2'd1, KL_256 = 2'd2, KL_BAD = 2'd3} key_len_t;
    typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} state_t;
    localparam logic [7:0] RCON_INIT = 8'h01;
    function automatic int max_words(input int max_nk);
        return 4 * (max_nk + 7);
    endfunction
    // Nk of 0 marks an illegal key length
    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        return kl == KL_128 ? 4'd4 : kl == KL_192 ? 4'd6 : kl == KL_256 ? 4'd8 : 4'd0;
    endfunction
    function automatic logic [3:0] nr_of(input logic [3:0] nk);
        return nk + 4'd6;
    endfunction
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
endpackage

// File: rtl/aes_4sbox.sv
// aes_4sbox: applies the AES forward S-box to each byte of a 32-bit word
module aes_4sbox (
    input  logic [31:0] din,
    output logic [31:0] dout
);
    localparam logic [0:255][7:0] SBOX = 2048'h
637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0b7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b27509832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cfd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2cd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdbe0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08ba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9ee1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16;
    for (genvar g = 0; g < 4; g++) begin : g_byte
        assign dout[8*g +: 8] = SBOX[din[8*g +: 8]];
    end
endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative FIPS-197 key schedule, one word per cycle, with round-key read port
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int MAX_NK   = 8,
    parameter int RK_IDX_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          key_len,
    input  logic [255:0]        key,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                rk_valid,
    input  logic [RK_IDX_W-1:0] rk_idx,
    output logic [127:0]        rk_data
);
    localparam int WORDS = max_words(MAX_NK);
    localparam int IW    = $clog2(WORDS);

    state_t        state, state_nx;
    logic [31:0]   w [WORDS];
    logic [IW-1:0] idx, last, base;
    logic [3:0]    nk, nr, phase, nk_in;
    logic [7:0]    rcon;
    logic [31:0]   prev, old, sin, sub, temp;
    logic          legal, launch;

    assign nk_in  = nk_of(key_len);
    assign legal  = nk_in != 4'd0 && 32'(nk_in) <= MAX_NK;
    assign launch = state == ST_IDLE && start && legal;
    assign ready  = state == ST_IDLE;
    assign busy   = state == ST_EXPAND;

    // phase is i mod Nk; phase 0 takes RotWord before the shared S-box
    assign prev = w[idx - IW'(1)];
    assign old  = w[idx - IW'(nk)];
    assign sin  = phase == 4'd0 ? {prev[23:0], prev[31:24]} : prev;
    assign temp = phase == 4'd0 ? sub ^ {rcon, 24'h0} : (nk == 4'd8 && phase == 4'd4) ? sub : prev;

    aes_4sbox u_sbox (.din(sin), .dout(sub));

    always_comb begin
        state_nx = state;
        if (launch) state_nx = ST_EXPAND;
        else if (state == ST_EXPAND && idx == last) state_nx = ST_DONE;
        else if (state == ST_DONE) state_nx = ST_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            done     <= 1'b0;
            err      <= 1'b0;
            rk_valid <= 1'b0;
        end else begin
            state    <= state_nx;
            done     <= state == ST_DONE;
            err      <= state == ST_IDLE && start && !legal;
            rk_valid <= launch ? 1'b0 : state == ST_DONE ? 1'b1 : rk_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (launch) begin
            for (int k = 0; k < MAX_NK; k++)
                if (k < 32'(nk_in)) w[k] <= key[255-32*k -: 32];
            nk    <= nk_in;
            nr    <= nr_of(nk_in);
            idx   <= IW'(nk_in);
            last  <= IW'({nr_of(nk_in), 2'b11});
            phase <= 4'd0;
            rcon  <= RCON_INIT;
        end else if (state == ST_EXPAND) begin
            w[idx] <= old ^ temp;
            idx    <= idx + IW'(1);
            phase  <= phase == nk - 4'd1 ? 4'd0 : phase + 4'd1;
            rcon   <= phase == 4'd0 ? xtime(rcon) : rcon;
        end
    end

    assign base    = IW'({rk_idx, 2'b00});
    assign rk_data = (rk_valid && 32'(rk_idx) <= 32'(nr))
                   ? {w[base], w[base + IW'(1)], w[base + IW'(2)], w[base + IW'(3)]} : '0;
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: directed FIPS-197 vectors for the iterative key schedule
module tb_aes_key_expand;
    logic         clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic [1:0]   key_len = 2'd0;
    logic [255:0] key = '0;
    logic         ready, busy, done, err, rk_valid;
    logic [3:0]   rk_idx = 4'd0;
    logic [127:0] rk_data;
    int           checks = 0, errors = 0;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    aes_key_expand dut (
        .clock(clock), .reset(reset), .start(start), .key_len(key_len), .key(key),
        .ready(ready), .busy(busy), .done(done), .err(err), .rk_valid(rk_valid),
        .rk_idx(rk_idx), .rk_data(rk_data)
    );

    always #5 clock = ~clock;

    // Leaves the caller at the falling edge right after the start edge; scrambles key inputs afterwards
    task automatic kick(input logic [1:0] kl, input logic [255:0] k);
        @(negedge clock);
        key_len = kl;
        key = k;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        key = ~k;
        key_len = 2'd0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 120) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({ready, busy, done, err, rk_valid} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 10000", {ready, busy, done, err, rk_valid});
        end
        checks++;
        if (rk_data !== 128'h0) begin
            errors++;
            $display("FAIL reset_rk_data: got %h expected 0", rk_data);
        end
    endtask

    task automatic test_aes128(input string tag);
        logic [3:0]   it [5] = '{4'd0, 4'd1, 4'd8, 4'd9, 4'd10};
        logic [127:0] et [5] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                                 128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
                                 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        int n;
        kick(2'd0, K128);
        checks++;
        if ({ready, busy, rk_valid} !== 3'b010) begin
            errors++;
            $display("FAIL %s_busy: got %b expected 010", tag, {ready, busy, rk_valid});
        end
        wait_done(n);
        checks++;
        if (n != 41) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected 41", tag, n);
        end
        checks++;
        if ({ready, rk_valid} !== 2'b11) begin
            errors++;
            $display("FAIL %s_valid: got %b expected 11", tag, {ready, rk_valid});
        end
        for (int i = 0; i < 5; i++) begin
            rk_idx = it[i];
            #1;
            checks++;
            if (rk_data !== et[i]) begin
                errors++;
                $display("FAIL %s_rk%0d: got %h expected %h", tag, it[i], rk_data, et[i]);
            end
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: got %b expected 0", tag, done);
        end
    endtask

    task automatic test_aes192();
        logic [3:0]   it [5] = '{4'd0, 4'd1, 4'd12, 4'd13, 4'd15};
        logic [127:0] et [5] = '{128'h8e73b0f7da0e6452c810f32b809079e5, 128'h62f8ead2522c6b7bfe0c91f72402f5a5,
                                 128'he98ba06f448c773c8ecc720401002202, 128'h0, 128'h0};
        int n;
        kick(2'd1, K192);
        wait_done(n);
        checks++;
        if (n != 47) begin
            errors++;
            $display("FAIL aes192_latency: got %0d expected 47", n);
        end
        for (int i = 0; i < 5; i++) begin
            rk_idx = it[i];
            #1;
            checks++;
            if (rk_data !== et[i]) begin
                errors++;
                $display("FAIL aes192_rk%0d: got %h expected %h", it[i], rk_data, et[i]);
            end
        end
    endtask

    task automatic test_aes256();
        logic [3:0]   it [4] = '{4'd0, 4'd1, 4'd2, 4'd14};
        logic [127:0] et [4] = '{128'h603deb1015ca71be2b73aef0857d7781, 128'h1f352c073b6108d72d9810a30914dff4,
                                 128'h9ba354118e6925afa51a8b5f2067fcde, 128'hfe4890d1e6188d0b046df344706c631e};
        int n;
        kick(2'd2, K256);
        wait_done(n);
        checks++;
        if (n != 53) begin
            errors++;
            $display("FAIL aes256_latency: got %0d expected 53", n);
        end
        for (int i = 0; i < 4; i++) begin
            rk_idx = it[i];
            #1;
            checks++;
            if (rk_data !== et[i]) begin
                errors++;
                $display("FAIL aes256_rk%0d: got %h expected %h", it[i], rk_data, et[i]);
            end
        end
    endtask

    task automatic test_illegal();
        kick(2'd3, K128);
        checks++;
        if ({err, ready, busy, rk_valid} !== 4'b1101) begin
            errors++;
            $display("FAIL illegal_pulse: got %b expected 1101", {err, ready, busy, rk_valid});
        end
        @(negedge clock);
        checks++;
        if ({err, ready, rk_valid} !== 3'b011) begin
            errors++;
            $display("FAIL illegal_clear: got %b expected 011", {err, ready, rk_valid});
        end
        rk_idx = 4'd14;
        #1;
        checks++;
        if (rk_data !== 128'hfe4890d1e6188d0b046df344706c631e) begin
            errors++;
            $display("FAIL illegal_keep_rk14: got %h expected fe4890d1e6188d0b046df344706c631e", rk_data);
        end
    endtask

    task automatic test_mid_reset();
        logic seen = 1'b0;
        kick(2'd2, K256);
        repeat (20) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        rk_idx = 4'd1;
        #1;
        checks++;
        if ({ready, busy, rk_valid, done} !== 4'b1000) begin
            errors++;
            $display("FAIL midreset_flags: got %b expected 1000", {ready, busy, rk_valid, done});
        end
        checks++;
        if (rk_data !== 128'h0) begin
            errors++;
            $display("FAIL midreset_rk_data: got %h expected 0", rk_data);
        end
        repeat (40) begin
            @(negedge clock);
            seen |= done;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_done: got %b expected 0", seen);
        end
        test_aes128("after_reset");
    endtask

    task automatic test_back_to_back();
        int pulses = 0, first = 0, n;
        kick(2'd0, K128);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clock);
            start = (c == 5);
            if (c == 5) begin
                key_len = 2'd1;
                key = K192;
            end
            if (done === 1'b1) begin
                pulses++;
                if (first == 0) first = c;
            end
        end
        checks++;
        if (pulses != 1 || first != 41) begin
            errors++;
            $display("FAIL ignore_start: got %0d pulses at %0d expected 1 at 41", pulses, first);
        end
        rk_idx = 4'd10;
        #1;
        checks++;
        if (rk_data !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++;
            $display("FAIL ignore_start_rk10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", rk_data);
        end
        kick(2'd1, K192);
        checks++;
        if ({rk_valid, busy} !== 2'b01) begin
            errors++;
            $display("FAIL restart_drop_valid: got %b expected 01", {rk_valid, busy});
        end
        wait_done(n);
        rk_idx = 4'd12;
        #1;
        checks++;
        if (n != 47 || rk_data !== 128'he98ba06f448c773c8ecc720401002202) begin
            errors++;
            $display("FAIL restart_rk12: got %h at %0d expected e98ba06f448c773c8ecc720401002202 at 47", rk_data, n);
        end
    endtask

    initial begin
        test_reset();
        test_aes128("aes128");
        test_aes192();
        test_aes256();
        test_illegal();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
